// File: rtl/pll_scan_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : pll_scan_pkg
//  Description : Shared definitions for the PLL scan-chain loader: loader
//                state encoding and default sizing constants.
//  Revision    : 1.0 - initial release
// ============================================================================
package pll_scan_pkg;

    // Default sizing of the scan chain and its surrounding handshakes.
    localparam int c_default_scan_len     = 144;   // bits in the PLL scan chain
    localparam int c_default_rom_latency  = 2;     // address -> rom_q cycles
    localparam int c_default_done_timeout = 1023;  // max cycles waiting for scandone

    // Loader state encoding (explicit 3-bit width).
    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_READ        = 3'd1,
        ST_DRAIN       = 3'd2,
        ST_WAIT_RECONF = 3'd3,
        ST_SHIFT       = 3'd4,
        ST_UPDATE      = 3'd5,
        ST_WAIT_DONE   = 3'd6
    } state_t;

endpackage : pll_scan_pkg
`default_nettype wire

// File: rtl/pll_scan_shifter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : pll_scan_shifter
//  Description : Capture buffer and two-phase serializer for the PLL scan
//                chain. ROM read requests are delayed by ROM_LATENCY cycles so
//                each returning rom_q bit lands at the index it was read from.
//                On i_shift_start the buffer is shifted out bit 0 first, each
//                bit taking a low-clock phase followed by a high-clock phase.
//  Ports       : clock, reset        - clock, async active-high reset
//                i_cap_ena/i_cap_addr - ROM read strobe/address as issued
//                i_rom_q             - serial ROM data
//                i_shift_start       - begin shifting on the next cycle
//                o_shift_last        - current cycle is the final high phase
//                o_scanclk/o_scanclkena/o_scandata - registered PLL scan pins
//  Revision    : 1.0 - initial release
// ============================================================================
module pll_scan_shifter
    import pll_scan_pkg::*;
#(
    parameter int SCAN_LEN    = c_default_scan_len,
    parameter int ROM_LATENCY = c_default_rom_latency
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       i_cap_ena,
    input  logic [7:0] i_cap_addr,
    input  logic       i_rom_q,
    input  logic       i_shift_start,
    output logic       o_shift_last,
    output logic       o_scanclk,
    output logic       o_scanclkena,
    output logic       o_scandata
);

    localparam int                c_idx_w    = (SCAN_LEN > 1) ? $clog2(SCAN_LEN) : 1;
    localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(SCAN_LEN - 1);

    logic [SCAN_LEN-1:0]    r_buf;
    logic [ROM_LATENCY-1:0] r_cap_vld;
    logic [7:0]             r_cap_addr [ROM_LATENCY];

    logic                   r_phase;
    logic [c_idx_w-1:0]     r_idx;
    logic                   r_sclk;
    logic                   r_sena;
    logic                   r_sdata;
    logic [c_idx_w-1:0]     w_idx_next;

    // Request delay line: the last stage lines up with the cycle in which the
    // ROM presents the data for that address.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cap_vld <= '0;
            for (int k = 0; k < ROM_LATENCY; k++) begin
                r_cap_addr[k] <= 8'd0;
            end
        end else begin
            r_cap_vld[0]  <= i_cap_ena;
            r_cap_addr[0] <= i_cap_addr;
            for (int k = 1; k < ROM_LATENCY; k++) begin
                r_cap_vld[k]  <= r_cap_vld[k-1];
                r_cap_addr[k] <= r_cap_addr[k-1];
            end
        end
    end

    // Capture buffer carries no reset: its contents are always rewritten
    // by a full READ pass before they are shifted out.
    always_ff @(posedge clock) begin
        if (r_cap_vld[ROM_LATENCY-1]) begin
            r_buf[r_cap_addr[ROM_LATENCY-1]] <= i_rom_q;
        end
    end

    assign w_idx_next = r_idx + 1'b1;

    // Two-phase serializer; r_sena doubles as the "shifting" flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_phase <= 1'b0;
            r_idx   <= '0;
            r_sclk  <= 1'b0;
            r_sena  <= 1'b0;
            r_sdata <= 1'b0;
        end else if (i_shift_start) begin
            r_phase <= 1'b0;
            r_idx   <= '0;
            r_sclk  <= 1'b0;
            r_sena  <= 1'b1;
            r_sdata <= r_buf[0];
        end else if (r_sena) begin
            if (!r_phase) begin
                r_phase <= 1'b1;
                r_sclk  <= 1'b1;
            end else if (r_idx == c_idx_last) begin
                r_phase <= 1'b0;
                r_sclk  <= 1'b0;
                r_sena  <= 1'b0;
                r_sdata <= 1'b0;
            end else begin
                r_phase <= 1'b0;
                r_sclk  <= 1'b0;
                r_idx   <= w_idx_next;
                r_sdata <= r_buf[w_idx_next];
            end
        end
    end

    assign o_shift_last = r_sena & r_phase & (r_idx == c_idx_last);
    assign o_scanclk    = r_sclk;
    assign o_scanclkena = r_sena;
    assign o_scandata   = r_sdata;

endmodule : pll_scan_shifter
`default_nettype wire

// File: rtl/pll_scan_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : pll_scan_loader
//  Description : Fetches a PLL configuration serially from a bit-wide ROM,
//                waits for the ROM's reconfig permission, shifts the bits into
//                the PLL scan chain, pulses configupdate and waits (bounded)
//                for scandone. SCAN_LEN must not exceed 256 and ROM_LATENCY
//                must be at least 1.
//  Ports       : clock, reset         - clock, async active-high reset
//                trigger_read         - start a fetch/load (IDLE only)
//                rom_address/rom_read_ena/rom_q - ROM read interface
//                reconfig             - ROM permission to start scan-out
//                scanclk/scanclkena/scandata/configupdate - PLL scan pins
//                scandone             - PLL scan-complete
//                busy/done/error      - status (error sticky until next load)
//  Revision    : 1.0 - initial release
// ============================================================================
module pll_scan_loader
    import pll_scan_pkg::*;
#(
    parameter int SCAN_LEN     = c_default_scan_len,
    parameter int ROM_LATENCY  = c_default_rom_latency,
    parameter int DONE_TIMEOUT = c_default_done_timeout
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       trigger_read,
    output logic [7:0] rom_address,
    output logic       rom_read_ena,
    input  logic       rom_q,
    input  logic       reconfig,
    output logic       scanclk,
    output logic       scanclkena,
    output logic       scandata,
    output logic       configupdate,
    input  logic       scandone,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int                   c_drain_w    = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY) : 1;
    localparam int                   c_wait_w     = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;
    localparam logic [7:0]           c_addr_last  = 8'(SCAN_LEN - 1);
    localparam logic [c_drain_w-1:0] c_drain_last = c_drain_w'(ROM_LATENCY - 1);
    localparam logic [c_wait_w-1:0]  c_wait_last  = c_wait_w'(DONE_TIMEOUT - 1);

    state_t               r_state;
    logic [7:0]           r_addr;
    logic                 r_rd_ena;
    logic                 r_cfg_upd;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_error;
    logic                 r_reconf_latched;
    logic [c_drain_w-1:0] r_drain_cnt;
    logic [c_wait_w-1:0]  r_wait_cnt;

    logic                 w_drain_last;
    logic                 w_shift_start;
    logic                 w_shift_last;

    assign w_drain_last = (r_state == ST_DRAIN) && (r_drain_cnt == c_drain_last);

    // Scan-out begins either straight out of DRAIN (permission already seen
    // or arriving in its last cycle) or on a reconfig pulse in WAIT_RECONF.
    assign w_shift_start = (w_drain_last && (r_reconf_latched || reconfig)) ||
                           ((r_state == ST_WAIT_RECONF) && reconfig);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state          <= ST_IDLE;
            r_addr           <= 8'd0;
            r_rd_ena         <= 1'b0;
            r_cfg_upd        <= 1'b0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_error          <= 1'b0;
            r_reconf_latched <= 1'b0;
            r_drain_cnt      <= '0;
            r_wait_cnt       <= '0;
        end else begin
            r_done    <= 1'b0;
            r_cfg_upd <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (trigger_read) begin
                        r_state          <= ST_READ;
                        r_error          <= 1'b0;
                        r_busy           <= 1'b1;
                        r_addr           <= 8'd0;
                        r_rd_ena         <= 1'b1;
                        r_reconf_latched <= 1'b0;
                    end
                end
                ST_READ: begin
                    if (r_addr == c_addr_last) begin
                        r_state     <= ST_DRAIN;
                        r_rd_ena    <= 1'b0;
                        r_drain_cnt <= '0;
                    end else begin
                        r_addr <= r_addr + 8'd1;
                    end
                end
                ST_DRAIN: begin
                    // The last requested bit is captured on the edge that
                    // leaves DRAIN, so the buffer is complete before shifting.
                    if (w_drain_last) begin
                        r_state          <= w_shift_start ? ST_SHIFT : ST_WAIT_RECONF;
                        r_reconf_latched <= 1'b0;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 1'b1;
                        if (reconfig) begin
                            r_reconf_latched <= 1'b1;
                        end
                    end
                end
                ST_WAIT_RECONF: begin
                    if (w_shift_start) begin
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (w_shift_last) begin
                        r_state   <= ST_UPDATE;
                        r_cfg_upd <= 1'b1;
                    end
                end
                ST_UPDATE: begin
                    r_state    <= ST_WAIT_DONE;
                    r_wait_cnt <= '0;
                end
                ST_WAIT_DONE: begin
                    if (scandone || (r_wait_cnt == c_wait_last)) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        if (!scandone) begin
                            r_error <= 1'b1;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_busy   <= 1'b0;
                    r_rd_ena <= 1'b0;
                end
            endcase
        end
    end

    pll_scan_shifter #(
        .SCAN_LEN    (SCAN_LEN),
        .ROM_LATENCY (ROM_LATENCY)
    ) u_shifter (
        .clock         (clock),
        .reset         (reset),
        .i_cap_ena     (r_rd_ena),
        .i_cap_addr    (r_addr),
        .i_rom_q       (rom_q),
        .i_shift_start (w_shift_start),
        .o_shift_last  (w_shift_last),
        .o_scanclk     (scanclk),
        .o_scanclkena  (scanclkena),
        .o_scandata    (scandata)
    );

    assign rom_address  = r_addr;
    assign rom_read_ena = r_rd_ena;
    assign configupdate = r_cfg_upd;
    assign busy         = r_busy;
    assign done         = r_done;
    assign error        = r_error;

endmodule : pll_scan_loader
`default_nettype wire

// File: tb/tb_pll_scan_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_pll_scan_loader
//  Description : Self-checking bench for pll_scan_loader. A 2-cycle ROM model
//                raises reconfig a programmable number of cycles after
//                rom_read_ena falls. Stimulus pushes expected scan bits,
//                configupdate and done events into queues; a negedge monitor
//                pops and compares them as the DUT produces them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_scan_loader;

    localparam int c_scan_len = 144;

    logic       clock = 1'b0;
    logic       reset;
    logic       trigger_read;
    logic [7:0] rom_address;
    logic       rom_read_ena;
    logic       rom_q;
    logic       reconfig;
    logic       scanclk;
    logic       scanclkena;
    logic       scandata;
    logic       configupdate;
    logic       scandone;
    logic       busy;
    logic       done;
    logic       error;

    logic rc_gen  = 1'b0;
    logic rc_stim = 1'b0;
    assign reconfig = rc_gen | rc_stim;

    always #5 clock = ~clock;

    pll_scan_loader #(
        .SCAN_LEN     (c_scan_len),
        .ROM_LATENCY  (2),
        .DONE_TIMEOUT (1023)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .trigger_read (trigger_read),
        .rom_address  (rom_address),
        .rom_read_ena (rom_read_ena),
        .rom_q        (rom_q),
        .reconfig     (reconfig),
        .scanclk      (scanclk),
        .scanclkena   (scanclkena),
        .scandata     (scandata),
        .configupdate (configupdate),
        .scandone     (scandone),
        .busy         (busy),
        .done         (done),
        .error        (error)
    );

    int errors = 0;
    int checks = 0;

    bit exp_bits[$];
    bit exp_cfg[$];
    bit exp_done[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- ROM model: 2-cycle latency bit array ----------------
    bit   rom_mem [c_scan_len];
    logic rom_d1 = 1'b0;
    logic rom_d2 = 1'b0;
    assign rom_q = rom_d2;

    always @(posedge clock) begin
        rom_d1 <= rom_read_ena ? rom_mem[rom_address] : 1'b0;
        rom_d2 <= rom_d1;
    end

    // reconfig pulse reconf_delay cycles after rom_read_ena falls
    int reconf_delay = 3;
    initial begin
        logic prev_ena;
        prev_ena = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            if (prev_ena && !rom_read_ena && !reset) begin
                repeat (reconf_delay) @(posedge clock);
                #1 rc_gen = 1'b1;
                @(posedge clock);
                #1 rc_gen = 1'b0;
            end
            prev_ena = rom_read_ena;
        end
    end

    // ---------------- Monitor / scoreboard ----------------
    int         cyc     = 0;
    int         last_hi = -10;
    logic [7:0] exp_addr = 8'd0;

    always @(negedge clock) begin
        cyc++;
        if (!reset) begin
            if (rom_read_ena) begin
                check("rom_address sequence", rom_address, exp_addr);
                exp_addr++;
            end else begin
                exp_addr = 8'd0;
            end
            if (scanclkena && scanclk) begin
                last_hi = cyc;
                check("scan bit expected", exp_bits.size() > 0, 1);
                if (exp_bits.size() > 0) begin
                    check("scandata", scandata, exp_bits.pop_front());
                end
            end
            if (configupdate) begin
                check("configupdate expected", exp_cfg.size() > 0, 1);
                if (exp_cfg.size() > 0) void'(exp_cfg.pop_front());
                check("configupdate after last scanclk high", cyc - last_hi, 1);
                check("scanclk in update", scanclk, 0);
                check("scanclkena in update", scanclkena, 0);
                check("scandata in update", scandata, 0);
            end
            if (done) begin
                check("done expected", exp_done.size() > 0, 1);
                if (exp_done.size() > 0) begin
                    check("error at done", error, exp_done.pop_front());
                end
                check("busy at done", busy, 0);
            end
        end
    end

    // ---------------- Stimulus ----------------
    function automatic bit pat_bit(input int kind, input int i);
        logic [7:0] b;
        case (kind)
            0:       begin b = 8'hA5; return b[i % 8]; end
            1:       begin b = 8'h3C; return b[i % 8]; end
            default: return ((i * 7) % 11) < 5;
        endcase
    endfunction

    task automatic run_cfg(input int kind, input int rdelay, input bit timeout,
                           input bit extra_trig, input bit abort);
        int n;
        for (int i = 0; i < c_scan_len; i++) begin
            rom_mem[i] = pat_bit(kind, i);
            exp_bits.push_back(pat_bit(kind, i));
        end
        exp_cfg.push_back(1'b1);
        exp_done.push_back(timeout);
        reconf_delay = rdelay;

        @(posedge clock); #1 trigger_read = 1'b1;
        @(posedge clock); #1 trigger_read = 1'b0;
        @(negedge clock);
        check("busy after trigger", busy, 1);
        check("rom_read_ena after trigger", rom_read_ena, 1);
        check("rom_address start", rom_address, 0);
        check("error cleared by trigger", error, 0);

        n = 0;
        while (rom_read_ena && n < 300) begin
            trigger_read = (extra_trig && rom_address == 8'd50);
            n++;
            @(negedge clock);
        end
        trigger_read = 1'b0;
        check("READ cycle count", n, c_scan_len);

        n = 0;
        while (!scanclkena && n < 50) begin
            n++;
            @(negedge clock);
        end
        check("SHIFT start after read_ena fall", n, (rdelay <= 1) ? 2 : rdelay + 1);
        check("busy in SHIFT", busy, 1);

        if (abort) begin
            repeat (140) @(negedge clock);
            check("phase 0 at bit 70", scanclk, 0);
            check("scanclkena at bit 70", scanclkena, 1);
            #2 reset = 1'b1;
            #1;
            check("abort rom_address", rom_address, 0);
            check("abort rom_read_ena", rom_read_ena, 0);
            check("abort scanclk", scanclk, 0);
            check("abort scanclkena", scanclkena, 0);
            check("abort scandata", scandata, 0);
            check("abort configupdate", configupdate, 0);
            check("abort busy", busy, 0);
            check("abort done", done, 0);
            check("abort error", error, 0);
            exp_bits.delete();
            exp_cfg.delete();
            exp_done.delete();
            @(negedge clock);
            #3 reset = 1'b0;
            repeat (6) @(negedge clock);
            check("busy after abort", busy, 0);
            check("scanclkena after abort", scanclkena, 0);
        end else begin
            if (extra_trig) begin
                repeat (20) @(negedge clock);
                trigger_read = 1'b1;
                @(negedge clock);
                trigger_read = 1'b0;
            end
            n = 0;
            while (!configupdate && n < 400) begin
                n++;
                @(negedge clock);
            end
            check("configupdate seen", configupdate, 1);

            n = 0;
            while (!done && n < 1100) begin
                scandone = (!timeout && n == 4);
                n++;
                @(negedge clock);
            end
            scandone = 1'b0;
            check("cycles configupdate to done", n, timeout ? 1024 : 5);
            check("error flag at done", error, timeout);
            @(negedge clock);
            check("done one cycle", done, 0);
            check("busy after done", busy, 0);
            check("error sticky", error, timeout);
        end
    endtask

    initial begin
        reset        = 1'b1;
        trigger_read = 1'b0;
        scandone     = 1'b0;
        #12;
        check("reset rom_address", rom_address, 0);
        check("reset rom_read_ena", rom_read_ena, 0);
        check("reset scanclk", scanclk, 0);
        check("reset scanclkena", scanclkena, 0);
        check("reset scandata", scandata, 0);
        check("reset configupdate", configupdate, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset error", error, 0);
        @(negedge clock);
        #3 reset = 1'b0;

        // reconfig while idle must not start anything
        @(negedge clock); rc_stim = 1'b1;
        @(negedge clock); rc_stim = 1'b0;
        repeat (4) @(negedge clock);
        check("idle reconfig busy", busy, 0);
        check("idle reconfig rom_read_ena", rom_read_ena, 0);
        check("idle reconfig scanclkena", scanclkena, 0);

        run_cfg(0, 3, 1'b0, 1'b0, 1'b0);  // 0xA5, normal completion
        run_cfg(0, 3, 1'b1, 1'b0, 1'b0);  // scandone never arrives
        repeat (3) @(negedge clock);
        check("error held in idle", error, 1);
        run_cfg(2, 1, 1'b0, 1'b1, 1'b0);  // reconfig in DRAIN, ignored triggers
        run_cfg(2, 3, 1'b0, 1'b0, 1'b1);  // reset at bit 70
        run_cfg(1, 2, 1'b0, 1'b0, 1'b0);  // normal load after abort

        repeat (5) @(negedge clock);
        check("pending scan bits", exp_bits.size(), 0);
        check("pending configupdates", exp_cfg.size(), 0);
        check("pending done pulses", exp_done.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "timeout");
    end

endmodule : tb_pll_scan_loader
`default_nettype wire
